// File: rtl/wiener_filter_apply.sv
// Per-block Wiener gain divider and pixel filter.
// Gain and mean are double-buffered so a block's gain is computed while the previous block streams.
module wiener_filter_apply #(
    parameter int DATA_WIDTH    = 8,
    parameter int TOTAL_SAMPLES = 64,
    parameter int GAIN_FRAC     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_of_frame,
    input  logic                      stats_valid,
    input  logic [2*DATA_WIDTH-1:0]   block_variance,
    input  logic [2*DATA_WIDTH-1:0]   block_mean,
    input  logic [2*DATA_WIDTH-1:0]   noise_variance,
    input  logic                      pixel_valid,
    input  logic [DATA_WIDTH-1:0]     pixel_in,
    output logic [DATA_WIDTH-1:0]     pixel_out,
    output logic                      pixel_out_valid,
    output logic                      gain_underrun,
    output logic                      stats_overrun
);
    localparam int SW = 2 * DATA_WIDTH;
    localparam int RW = SW + 1;
    localparam int GW = GAIN_FRAC + 1;
    localparam int CW = $clog2(TOTAL_SAMPLES);
    localparam int KW = $clog2(GAIN_FRAC + 1);
    localparam int PW = DATA_WIDTH + GAIN_FRAC + 2;
    localparam logic [GW-1:0]        GAIN_ONE = {1'b1, {GAIN_FRAC{1'b0}}};
    localparam logic [KW-1:0]        LAST_BIT = KW'(GAIN_FRAC);
    localparam logic signed [PW-1:0] PIX_MAX  = $signed({{(PW-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}});

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                   state_r, state_nxt_s;
    logic [RW-1:0]            rem_r, rem_sub_s;
    logic [SW-1:0]            divisor_r;
    logic [GW-1:0]            quot_r, gain_sat_s;
    logic [KW-1:0]            bit_cnt_r;
    logic [DATA_WIDTH-1:0]    mean_lat_r;
    logic                     rem_ge_s, num_zero_s, done_s, promote_s;

    logic [GW-1:0]            gain_pend_r, gain_act_r, gain_use_s;
    logic [DATA_WIDTH-1:0]    mean_pend_r, mean_act_r, mean_use_s;
    logic                     pend_valid_r;
    logic [CW-1:0]            pix_count_r;

    logic signed [DATA_WIDTH:0] diff_s;
    logic signed [PW-1:0]       prod_s, shifted_s, sum_s;
    logic signed [PW-1:0]       s1_prod_r;
    logic [DATA_WIDTH-1:0]      s1_mean_r, clamp_s;
    logic                       s1_valid_r;

    // Divider control, restoring-step arithmetic and quotient saturation
    always_comb begin
        state_nxt_s = state_r;
        num_zero_s  = (block_variance == {SW{1'b0}}) || (block_variance <= noise_variance);
        rem_ge_s    = (rem_r >= {1'b0, divisor_r});
        done_s      = (state_r == ST_DONE);
        promote_s   = pixel_valid && (pix_count_r == {CW{1'b0}});
        if (rem_ge_s) begin
            rem_sub_s = rem_r - {1'b0, divisor_r};
        end else begin
            rem_sub_s = rem_r;
        end
        if (quot_r > GAIN_ONE) begin
            gain_sat_s = GAIN_ONE;
        end else begin
            gain_sat_s = quot_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (stats_valid) begin
                    state_nxt_s = ST_DIV;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (bit_cnt_r == LAST_BIT) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DIV;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Divider state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            rem_r      <= {RW{1'b0}};
            divisor_r  <= {SW{1'b0}};
            quot_r     <= {GW{1'b0}};
            bit_cnt_r  <= {KW{1'b0}};
            mean_lat_r <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (stats_valid) begin
                        // Divisor forced non-zero so a zero numerator always yields gain 0
                        rem_r      <= num_zero_s ? {RW{1'b0}} : {1'b0, block_variance - noise_variance};
                        divisor_r  <= (block_variance == {SW{1'b0}}) ? SW'(1) : block_variance;
                        quot_r     <= {GW{1'b0}};
                        bit_cnt_r  <= {KW{1'b0}};
                        mean_lat_r <= block_mean[DATA_WIDTH-1:0];
                    end
                end
                ST_DIV: begin
                    quot_r    <= {quot_r[GW-2:0], rem_ge_s};
                    rem_r     <= {rem_sub_s[RW-2:0], 1'b0};
                    bit_cnt_r <= bit_cnt_r + KW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Pending/active gain buffers and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gain_pend_r   <= {GW{1'b0}};
            mean_pend_r   <= {DATA_WIDTH{1'b0}};
            pend_valid_r  <= 1'b0;
            gain_act_r    <= {GW{1'b0}};
            mean_act_r    <= {DATA_WIDTH{1'b0}};
            gain_underrun <= 1'b0;
            stats_overrun <= 1'b0;
        end else begin
            if (promote_s && pend_valid_r) begin
                gain_act_r <= gain_pend_r;
                mean_act_r <= mean_pend_r;
            end
            // A DONE write wins over the clear from a same-cycle promotion
            if (done_s) begin
                gain_pend_r  <= gain_sat_s;
                mean_pend_r  <= mean_lat_r;
                pend_valid_r <= 1'b1;
            end else if (promote_s && pend_valid_r) begin
                pend_valid_r <= 1'b0;
            end
            if (start_of_frame) begin
                gain_underrun <= 1'b0;
                stats_overrun <= 1'b0;
            end else begin
                if (promote_s && !pend_valid_r) begin
                    gain_underrun <= 1'b1;
                end
                if ((stats_valid && (state_r != ST_IDLE)) || (done_s && pend_valid_r)) begin
                    stats_overrun <= 1'b1;
                end
            end
        end
    end

    // Pixel position within the block
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_count_r <= {CW{1'b0}};
        end else if (start_of_frame) begin
            pix_count_r <= {CW{1'b0}};
        end else if (pixel_valid) begin
            pix_count_r <= pix_count_r + CW'(1);
        end
    end

    // First pixel of a block sees the freshly promoted gain and mean; output clamp
    always_comb begin
        if (promote_s && pend_valid_r) begin
            gain_use_s = gain_pend_r;
            mean_use_s = mean_pend_r;
        end else begin
            gain_use_s = gain_act_r;
            mean_use_s = mean_act_r;
        end
        diff_s    = $signed({1'b0, pixel_in}) - $signed({1'b0, mean_use_s});
        prod_s    = PW'(diff_s) * $signed({{(PW-GW){1'b0}}, gain_use_s});
        shifted_s = s1_prod_r >>> GAIN_FRAC;
        sum_s     = shifted_s + $signed({{(PW-DATA_WIDTH){1'b0}}, s1_mean_r});
        if (sum_s[PW-1]) begin
            clamp_s = {DATA_WIDTH{1'b0}};
        end else if (sum_s > PIX_MAX) begin
            clamp_s = {DATA_WIDTH{1'b1}};
        end else begin
            clamp_s = sum_s[DATA_WIDTH-1:0];
        end
    end

    // Two-stage pixel pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_prod_r       <= {PW{1'b0}};
            s1_mean_r       <= {DATA_WIDTH{1'b0}};
            s1_valid_r      <= 1'b0;
            pixel_out       <= {DATA_WIDTH{1'b0}};
            pixel_out_valid <= 1'b0;
        end else begin
            s1_valid_r      <= pixel_valid;
            pixel_out_valid <= s1_valid_r;
            if (pixel_valid) begin
                s1_prod_r <= prod_s;
                s1_mean_r <= mean_use_s;
            end
            if (s1_valid_r) begin
                pixel_out <= clamp_s;
            end
        end
    end

endmodule

// File: doc/wiener_filter_apply.md
Name: wiener_filter_apply

Overview:
- Downstream consumer of the per-block Wiener statistics stage.
- For each block it computes a fixed-point Wiener gain, gain = max(var − noise, 0) / var, using an iterative divider.
- It then filters the delayed pixel stream: out = mean + gain·(pixel − mean), clamped to the pixel range.
- Gain and mean are double-buffered, so the next block's gain is computed while the current block's pixels stream.

Parameters:
- DATA_WIDTH, 8: pixel width.
- TOTAL_SAMPLES, 64: pixels per block; must be a power of 2.
- GAIN_FRAC, 8: fractional bits of the gain; gain range is 0 to 2^GAIN_FRAC (1.0).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start_of_frame  in  1  pulse; clears the pixel counter and the error flags.
- stats_valid  in  1  pulse; block_variance and block_mean are valid this cycle.
- block_variance  in  2*DATA_WIDTH  block variance, unsigned integer.
- block_mean  in  2*DATA_WIDTH  block mean; only the low DATA_WIDTH bits are used.
- noise_variance  in  2*DATA_WIDTH  frame noise variance; sampled on stats_valid.
- pixel_valid  in  1  pixel_in is valid this cycle.
- pixel_in  in  DATA_WIDTH  delayed pixel, block-ordered.
- pixel_out  out  DATA_WIDTH  filtered pixel.
- pixel_out_valid  out  1  pixel_out is valid this cycle.
- gain_underrun  out  1  sticky: a block started before its gain was ready.
- stats_overrun  out  1  sticky: stats_valid arrived while the divider was busy.

Behaviour:
- Reset (async, rst=1): all outputs 0; FSM in IDLE; pix_count 0; pending_valid 0; active gain 0; active mean 0.
- Divider FSM:
  - States: IDLE → DIV → DONE → IDLE.
  - IDLE + stats_valid:
    - Latch mean.
    - If var == 0 or var ≤ noise: numerator = 0.
    - Otherwise: numerator = (var − noise) << GAIN_FRAC, divisor = var.
    - Go to DIV.
  - DIV: restoring division, one quotient bit per cycle, GAIN_FRAC+1 cycles.
  - DONE:
    - Write gain_pending and mean_pending; set pending_valid.
    - Go to IDLE.
    - pending_valid is visible exactly GAIN_FRAC+3 cycles after the stats_valid edge.
  - Quotient is truncated (floor) and saturated to 2^GAIN_FRAC.
  - stats_valid while in DIV or DONE: the stats are ignored; set stats_overrun.
  - If DONE occurs while pending_valid is already 1: overwrite pending and set stats_overrun.
- Pixel counter:
  - pix_count increments on pixel_valid.
  - Wraps from TOTAL_SAMPLES−1 to 0.
  - start_of_frame forces pix_count to 0; start_of_frame has priority over pixel_valid in the same cycle.
- Block promotion (pixel_valid with pix_count == 0):
  - If pending_valid (registered value, before this cycle's DONE write): active ← pending; clear pending_valid; this pixel already uses the new gain and mean (combinational select).
  - Otherwise: keep the previous active gain and mean; set gain_underrun.
  - A DONE in the same cycle as a promotion attempt is not visible to that promotion: the underrun is flagged and pending is written.
- Pixel datapath, 2-cycle latency (pixel_valid at cycle t → pixel_out_valid at t+2):
  - Stage 1: diff = pixel − mean, signed DATA_WIDTH+1 bits; prod = diff · gain, signed DATA_WIDTH+GAIN_FRAC+2 bits; mean registered alongside.
  - Stage 2: y = mean + (prod >>> GAIN_FRAC), arithmetic shift (floor); clamp to [0, 2^DATA_WIDTH−1].
  - pixel_out_valid is a pure 2-stage delay of pixel_valid; gaps in pixel_valid are preserved.
- Flags: gain_underrun and stats_overrun are cleared only by rst or start_of_frame.
- Reset mid-division: the FSM aborts to IDLE and nothing is written to pending.

Test Plan:
- Nominal gain: var=100, noise=36, mean=100, GAIN_FRAC=8.
  - Response: gain=163 after 11 cycles.
  - pixel 200 → 163; pixel 0 → 36 (−100·163 = −16300, >>>8 = −64).
- Zero and full gain:
  - var=50, noise=80 → gain 0; every pixel of the block outputs the mean (e.g. mean=77 → 77).
  - noise=0, var=400 → gain 256; pixel_out equals pixel_in for 0, 128, 255.
- Degenerate and clamp: var=0 gives gain 0 with no division fault; the output is never outside 0..255 for a pixel/mean sweep at gain 256.
- Double buffer: stream two 64-pixel blocks back-to-back.
  - Send the second block's stats_valid 20 cycles into block 1.
  - Response: block 1 outputs use gain A; block 2 uses gain B from its first pixel; no flags set.
- Underrun and overrun:
  - Start block 2 pixels 5 cycles after its stats_valid → gain_underrun=1; block 2 uses the old gain.
  - Two stats_valid 3 cycles apart → stats_overrun=1; the second set is ignored.
- Reset and frame: assert rst during DIV → outputs 0, pending_valid 0; start_of_frame mid-block → pix_count 0 and flags cleared.
